// File: rtl/cfg_sched_pkg.sv
// cfg_sched_pkg: shared constants and state encoding for the configuration frame scheduler
package cfg_sched_pkg;
    localparam int CFG_WORDS = 5;
    localparam int CFG_W = 160;
    localparam logic [31:0] TIMEOUT_STATUS = 32'h0;
    typedef enum logic [1:0] {IDLE, SEND, WAIT_STS, DONE} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning upward from rr_ptr modulo NREQ
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int GW = NREQ > 1 ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [GW-1:0]   grant_id
);
    // Scan in reverse so the last hit written is the first one in round-robin order
    always_comb begin
        grant = '0;
        grant_id = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr) + k) % NREQ]) begin
                grant = '0;
                grant[(int'(rr_ptr) + k) % NREQ] = 1'b1;
                grant_id = GW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end
endmodule

// File: rtl/cfg_frame_sched.sv
// cfg_frame_sched: round-robin scheduler serializing 160-bit config frames onto a 32-bit AXIS link
module cfg_frame_sched
    import cfg_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int TIMEOUT = 1023,
    localparam int GW = NREQ > 1 ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*CFG_W-1:0] req_frame,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       done_valid,
    output logic [31:0]           done_status,
    output logic                  done_timeout,
    output logic [31:0]           m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic [31:0]           s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  busy,
    output logic [GW-1:0]         grant_id
);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t                       state, state_nx;
    logic [GW-1:0]                rr_ptr, win_idx;
    logic [NREQ-1:0]              win;
    logic [CFG_WORDS-1:0][31:0]   frame;
    logic [2:0]                   beat;
    logic [TW-1:0]                tcnt;
    logic [31:0]                  sts;
    logic                         tmo;
    logic                         beat_acc, last_beat, sts_acc, tmo_hit;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req      (req_valid),
        .rr_ptr   (rr_ptr),
        .grant    (win),
        .grant_id (win_idx)
    );

    assign beat_acc  = state == SEND && m_axis_tready;
    assign last_beat = beat_acc && beat == 3'(CFG_WORDS - 1);
    assign sts_acc   = state == WAIT_STS && s_axis_tvalid;
    assign tmo_hit   = state == WAIT_STS && tcnt == TW'(TIMEOUT - 1);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = |win ? SEND : IDLE;
            SEND:     state_nx = last_beat ? WAIT_STS : SEND;
            WAIT_STS: state_nx = sts_acc || tmo_hit ? DONE : WAIT_STS;
            default:  state_nx = IDLE;
        endcase
    end

    // A status word on the final timeout cycle takes precedence over the timeout
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr   <= '0;
            grant_id <= '0;
            frame    <= '0;
            beat     <= '0;
            tcnt     <= '0;
            sts      <= '0;
            tmo      <= 1'b0;
        end else begin
            if (state == IDLE && |win) begin
                frame    <= req_frame[int'(win_idx)*CFG_W +: CFG_W];
                grant_id <= win_idx;
                beat     <= '0;
            end
            if (beat_acc)
                beat <= beat + 3'd1;
            tcnt <= state == WAIT_STS ? tcnt + 1'b1 : '0;
            if (sts_acc) begin
                sts <= s_axis_tdata;
                tmo <= 1'b0;
            end else if (tmo_hit) begin
                sts <= TIMEOUT_STATUS;
                tmo <= 1'b1;
            end
            if (state == DONE)
                rr_ptr <= grant_id == GW'(NREQ - 1) ? '0 : grant_id + 1'b1;
        end
    end

    always_comb begin
        req_ready     = state == IDLE && aresetn ? win : '0;
        m_axis_tvalid = state == SEND;
        m_axis_tdata  = state == SEND ? frame[beat] : '0;
        s_axis_tready = state == WAIT_STS;
        busy          = state != IDLE;
        done_valid    = state == DONE ? NREQ'(1) << grant_id : '0;
        done_status   = state == DONE ? sts : '0;
        done_timeout  = state == DONE && tmo;
    end
endmodule

// File: tb/tb_cfg_frame_sched.sv
// tb_cfg_frame_sched: directed and randomized checks of cfg_frame_sched against a transaction-level model
module tb_cfg_frame_sched;
    localparam int NREQ = 2;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              aresetn;
    logic [NREQ-1:0]   req_valid, req_ready, done_valid;
    logic [NREQ*160-1:0] req_frame;
    logic [31:0]       done_status, m_axis_tdata, s_axis_tdata;
    logic              done_timeout, m_axis_tvalid, m_axis_tready;
    logic              s_axis_tvalid, s_axis_tready, busy;
    logic [0:0]        grant_id;

    cfg_frame_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .req_valid     (req_valid),
        .req_frame     (req_frame),
        .req_ready     (req_ready),
        .done_valid    (done_valid),
        .done_status   (done_status),
        .done_timeout  (done_timeout),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int rr);
        for (int k = 0; k < NREQ; k++)
            if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] r = '0;
        if (i >= 0) r[i] = 1'b1;
        return r;
    endfunction

    function automatic int idx_of(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [159:0] rnd_frame();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Transaction model: phase 0 idle, 1 sending, 2 awaiting status, 3 completion due
    int ph = 0, cur_id = 0, bi = 0, model_rr = 0;
    int last_acc = 0, last_w = 0, last_done = 0, last_id = 0;
    int n_done = 0, n_beats = 0, n_stall = 0;
    logic [159:0] cur_frame;
    logic [31:0] exp_sts, last_sts, first_tdata;
    logic exp_tmo, last_tmo;
    logic [NREQ-1:0] seen_ready = '0;
    logic s_prev_rdy = 1'b0, s_prev_acc = 1'b0;
    int gq[$];

    always @(negedge clk) begin : mon
        int p, e;
        if (!aresetn) begin
            check("rst_req_ready", req_ready, 0);
            check("rst_done", {done_valid, done_timeout}, 0);
            check("rst_done_status", done_status, 0);
            check("rst_m_axis", {m_axis_tvalid, m_axis_tdata}, 0);
            check("rst_s_tready", s_axis_tready, 0);
            check("rst_busy", busy, 0);
            check("rst_grant_id", grant_id, 0);
            ph = 0;
            model_rr = 0;
            seen_ready = '0;
            s_prev_rdy = 1'b0;
            s_prev_acc = 1'b0;
        end else begin
            p = ph;
            e = pick(req_valid, model_rr);
            check("req_ready", req_ready, p == 0 ? onehot(e) : '0);
            check("busy", busy, p != 0);
            if (p != 0) check("grant_id", grant_id, cur_id);
            check("m_tvalid", m_axis_tvalid, p == 1);
            check("s_tready", s_axis_tready, p == 2);
            check("done_valid", done_valid, p == 3 ? onehot(cur_id) : '0);
            if (m_axis_tvalid && m_axis_tready) n_beats++;
            if (m_axis_tvalid && !m_axis_tready) n_stall++;
            if (p == 0 && req_ready != 0) begin
                cur_id = e;
                cur_frame = req_frame[e*160 +: 160];
                ph = 1;
                bi = 0;
                last_acc = cyc;
                gq.push_back(idx_of(req_ready));
            end
            if (p == 1) begin
                check("m_tdata", m_axis_tdata, cur_frame[bi*32 +: 32]);
                if (bi == 0) first_tdata = m_axis_tdata;
                if (m_axis_tready) begin
                    bi++;
                    if (bi == 5) begin
                        ph = 2;
                        last_w = cyc + 1;
                    end
                end
            end
            if (p == 2) begin
                if (s_axis_tvalid) begin
                    exp_sts = s_axis_tdata;
                    exp_tmo = 1'b0;
                    ph = 3;
                end else if (cyc - last_w == TIMEOUT - 1) begin
                    exp_sts = 32'h0;
                    exp_tmo = 1'b1;
                    ph = 3;
                end
            end
            if (p == 3) begin
                check("done_status", done_status, exp_sts);
                check("done_timeout", done_timeout, exp_tmo);
                last_done = cyc;
                last_sts = done_status;
                last_tmo = done_timeout;
                last_id = idx_of(done_valid);
                model_rr = (cur_id + 1) % NREQ;
                n_done++;
                ph = 0;
            end
            seen_ready = req_ready;
            s_prev_rdy = s_axis_tready;
            s_prev_acc = s_axis_tready && s_axis_tvalid;
        end
    end

    // Stimulus knobs: pending frames per requester, tready pattern, status delay in WAIT cycles
    int pend[NREQ];
    int tr_mode = 0, tp = 0, sts_d = 0, wc = 0;
    bit sts_rand = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (cyc > 40000) begin
            $display("FAIL watchdog: cycle budget exhausted at %0d", cyc);
            $fatal(1, "watchdog");
        end
        if (s_prev_acc && sts_rand) s_axis_tdata = $urandom;
        if (!s_prev_rdy && sts_rand)
            sts_d = $urandom_range(0, 3) == 0 ? 0 : int'($urandom_range(1, TIMEOUT + 2));
        wc = s_prev_rdy ? wc + 1 : 0;
        s_axis_tvalid = sts_d == 0 || wc == sts_d;
        m_axis_tready = tr_mode == 0 ? 1'b1 : tr_mode == 1 ? tp % 3 == 0 : 1'($urandom_range(0, 1));
        tp++;
        for (int i = 0; i < NREQ; i++) begin
            if (seen_ready[i]) begin
                pend[i]--;
                req_frame[i*160 +: 160] = rnd_frame();
            end
            req_valid[i] = pend[i] > 0;
        end
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (n_done < target && k < 3000) begin
            tick();
            k++;
        end
        check("wait_done", n_done >= target, 1);
    endtask

    task automatic wait_quiet();
        int k = 0;
        while ((pend[0] + pend[1] > 0 || ph != 0) && k < 8000) begin
            tick();
            k++;
        end
        check("drain", pend[0] + pend[1] == 0 && ph == 0, 1);
    endtask

    initial begin
        int d0, s0, b0;
        logic [159:0] rf;
        aresetn = 1'b0;
        req_valid = '0;
        req_frame = '0;
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        pend = '{default: 0};
        repeat (3) tick();
        aresetn = 1'b1;
        // contention: alternating grants, pointer wraps back to requester 0
        gq.delete();
        req_frame = {rnd_frame(), rnd_frame()};
        pend = '{2, 2};
        wait_done(n_done + 4);
        check("grant_cnt", gq.size(), 4);
        for (int i = 0; i < 4 && i < gq.size(); i++) check("grant_seq", gq[i], i % 2);
        gq.delete();
        pend = '{1, 1};
        wait_done(n_done + 2);
        check("rr_wrap", gq.size() > 0 ? gq[0] : -1, 0);
        // single request, nominal latency
        s_axis_tdata = 32'hA5A5A5A5;
        req_frame[159:0] = {32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        pend[0] = 1;
        b0 = n_beats;
        wait_done(n_done + 1);
        check("t1_latency", last_done - last_acc, 7);
        check("t1_first_beat", first_tdata, 32'h11111111);
        check("t1_status", last_sts, 32'hA5A5A5A5);
        check("t1_timeout", last_tmo, 0);
        check("t1_id", last_id, 0);
        check("t1_beats", n_beats - b0, 5);
        // backpressure 1,0,0,...
        tr_mode = 1;
        tp = 0;
        pend[1] = 1;
        s0 = n_stall;
        b0 = n_beats;
        wait_done(n_done + 1);
        check("bp_stalled", n_stall - s0 > 0, 1);
        check("bp_latency", last_done - last_acc, 7 + n_stall - s0);
        check("bp_beats", n_beats - b0, 5);
        check("bp_id", last_id, 1);
        tr_mode = 0;
        // timeout, then a normal transfer
        sts_d = 99;
        pend[0] = 1;
        wait_done(n_done + 1);
        check("to_timeout", last_tmo, 1);
        check("to_status", last_sts, 0);
        check("to_latency", last_done - last_w, TIMEOUT);
        sts_d = 0;
        s_axis_tdata = 32'h12345678;
        pend[1] = 1;
        wait_done(n_done + 1);
        check("after_to_timeout", last_tmo, 0);
        check("after_to_status", last_sts, 32'h12345678);
        // status on the final timeout cycle wins
        s_axis_tdata = 32'hDEADBEEF;
        sts_d = TIMEOUT - 1;
        pend[0] = 1;
        wait_done(n_done + 1);
        check("race_timeout", last_tmo, 0);
        check("race_status", last_sts, 32'hDEADBEEF);
        check("race_latency", last_done - last_w, TIMEOUT);
        // reset during SEND after beat 2
        sts_d = 0;
        rf = rnd_frame();
        req_frame[159:0] = rf;
        pend[0] = 2;
        for (int k = 0; k < 200 && !(ph == 1 && bi == 3); k++) tick();
        check("rst_reach_beat3", ph == 1 && bi == 3, 1);
        aresetn = 1'b0;
        #1;
        check("rst_drop_tvalid", m_axis_tvalid, 0);
        check("rst_drop_s_tready", s_axis_tready, 0);
        d0 = n_done;
        repeat (2) tick();
        req_frame[159:0] = rf;
        pend[0] = 1;
        req_valid[0] = 1'b1;
        aresetn = 1'b1;
        wait_done(d0 + 1);
        check("rst_one_done", n_done - d0, 1);
        check("rst_regrant_id", last_id, 0);
        check("rst_first_beat", first_tdata, rf[31:0]);
        // randomized traffic
        sts_rand = 1'b1;
        for (int r = 0; r < 6; r++) begin
            tr_mode = $urandom_range(0, 2);
            pend = '{$urandom_range(1, 6), $urandom_range(0, 6)};
            wait_quiet();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cfg_frame_sched.md
# cfg_frame_sched

Scheduler that shares the 160-bit configuration channel between several requesters (PS-side control, internal calibration engine, etc.). Each requester presents a full 160-bit frame. The block grants one requester at a time by round-robin, serializes its frame onto the 32-bit AXI4-Stream configuration link as 5 beats, then waits for the 32-bit status word returned by the configuration interface. It reports that status, or a timeout, back to the granted requester. It sits between the requesters and the configuration interface's AXIS slave/master pair.

## Interface
Parameters:
- NREQ, 2: number of requesters (2..8).
- TIMEOUT, 1023: max cycles spent waiting for the status word.

Ports:
- clk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  requester i has a frame pending.
- req_frame  in  NREQ*160  frame of requester i at bits [160*i+159:160*i].
- req_ready  out  NREQ  frame of requester i accepted this cycle.
- done_valid  out  NREQ  one-cycle completion pulse to requester i.
- done_status  out  32  status word (0 on timeout).
- done_timeout  out  1  completion was a timeout.
- m_axis_tdata  out  32  config beat.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- s_axis_tdata  in  32  status word from the configuration interface.
- s_axis_tvalid  in  1  status valid.
- s_axis_tready  out  1  status accepted.
- busy  out  1  state != IDLE.
- grant_id  out  $clog2(NREQ) (min 1)  current or most recent grantee.

## Operation
- FSM states and transitions:
  - IDLE: if any req_valid, go to SEND.
  - SEND: after beat 4 is accepted, go to WAIT_STS.
  - WAIT_STS: when a status word is accepted or the timeout is hit, go to DONE.
  - DONE: go to IDLE unconditionally.
- Arbitration: winner = first i with req_valid[i], scanning from rr_ptr upward modulo NREQ. req_ready[winner] = (state==IDLE) is combinational and one-hot or zero. At that edge, req_frame[winner] is latched, grant_id is set to winner, and the beat counter is cleared.
- rr_ptr updates in DONE to (grant_id+1) mod NREQ. It does not change when no grant occurs.
- SEND: m_axis_tvalid=1. m_axis_tdata = frame word k, with k=0 being bits [31:0] and k=4 being bits [159:128]. Data stays stable while tvalid=1 and tready=0. k increments on each tvalid&&tready. Frame beats are never interleaved between requesters.
- WAIT_STS: s_axis_tready=1 and the timeout counter increments each cycle. On s_axis_tvalid, status is latched with timeout=0. If the counter reaches TIMEOUT-1 without status, the result is status 0 with timeout=1. If status and the last timeout cycle coincide, status wins.
- s_axis_tready=0 outside WAIT_STS. Stray status words are back-pressured, not consumed.
- DONE: done_valid[grant_id]=1 for exactly one cycle, with done_status and done_timeout valid in the same cycle.
- req_valid deasserting after acceptance has no effect. Requester changes to req_frame after acceptance are ignored.

## Timing
- Reset values: IDLE, rr_ptr=0, grant_id=0, beat counter 0, timeout counter 0. All outputs are 0: req_ready, done_valid, done_status, done_timeout, m_axis_tdata, m_axis_tvalid, s_axis_tready, busy.
- Reset assertion mid-operation immediately drops m_axis_tvalid and s_axis_tready. The frame is abandoned with no done pulse. The downstream interface shares aresetn, so its word counter realigns.
- With m_axis_tready=1 and status returned in the first WAIT_STS cycle:
  - acceptance at edge 0;
  - beats in cycles 1..5;
  - WAIT_STS in cycle 6;
  - done_valid in cycle 7;
  - IDLE in cycle 8.
- Minimum issue interval is therefore 8 cycles.
- Each tready=0 cycle in SEND adds one cycle. Timeout completion occurs TIMEOUT cycles after WAIT_STS entry, plus the DONE cycle.
- Timeout counter width: $clog2(TIMEOUT+1). It is cleared on entry to WAIT_STS.

## Structure
- Package cfg_sched_pkg:
  - CFG_WORDS=5 and CFG_W=160;
  - state enum {IDLE, SEND, WAIT_STS, DONE};
  - timeout status constant (32'h0).
- Sub-module rr_arbiter (NREQ parameter): inputs are the req vector and rr_ptr; output is a one-hot grant plus an index. It is purely combinational. The rest of the logic lives in cfg_frame_sched.

## Test plan
- Single request: req_valid=01, frame words 0x11111111..0x55555555, tready=1, status 0xA5A5A5A5 in first WAIT cycle -> beats 0x11111111..0x55555555 in cycles 1..5; done_valid=01 in cycle 7 with status 0xA5A5A5A5 and timeout 0.
- Contention: both requesters held valid for 4 frames -> grants alternate 0,1,0,1; no beat interleave; rr_ptr returns to 0.
- Backpressure: tready toggles 1,0,0,1,… -> each beat is held stable while tready=0; exactly 5 beats total; done is delayed by the number of stall cycles.
- Timeout: TIMEOUT=16, s_axis_tvalid never asserted -> done_valid 16 cycles after WAIT entry, done_timeout=1, done_status=0; next request is served normally.
- Edge race: status arrives on the last timeout cycle -> done_timeout=0 and the status is reported. A status word presented during SEND is not accepted (s_axis_tready=0).
- Reset mid-SEND after beat 2: m_axis_tvalid=0 immediately and no done pulse. After release, the same request is re-granted and all 5 beats start from word 0.
